// File: rtl/cache_set_ctrl.sv
// cache_set_ctrl: sequences one CPU access at a time through a 4-way cache
// set. The flow is lookup, optional victim writeback, line fill, allocation,
// then response.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss/writeback counters.
module cache_set_ctrl #(
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 19,
   parameter int IDX_W  = 8,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [IDX_W-1:0]  set_idx,
   output logic [TAG_W-1:0]  set_tag,
   output logic              set_en,
   output logic              set_check,
   output logic              set_alloc,
   output logic              set_evict,
   output logic              set_change,
   input  logic              set_hit,
   input  logic              set_dirty,
   input  logic              set_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack
`ifdef CACHE_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_hits,
   output logic [STAT_W-1:0] stat_misses,
   output logic [STAT_W-1:0] stat_wbacks
`endif
);

   localparam int OFF_W = ADDR_W - TAG_W - IDX_W;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      WRITEBACK,
      FILL,
      ALLOC,
      RESPOND
   } state_t;

   state_t             state, state_nx;
   logic [TAG_W-1:0]   tag_q;
   logic [IDX_W-1:0]   idx_q;
   logic               we_q;
   logic               hit_q;
   logic               wb_busy;   // high after the first WRITEBACK cycle

   // Byte-offset bits of the request address do not take part in the access.
   generate
      if (OFF_W > 0) begin : g_off
         logic unused_off;
         assign unused_off = ^req_addr[OFF_W-1:0];
      end
   endgenerate

   // State register plus the per-access latches (tag, index, write flag, hit).
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         tag_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         hit_q   <= 1'b0;
         wb_busy <= 1'b0;
      end else begin
         state   <= state_nx;
         wb_busy <= (state == WRITEBACK);
         if (state == IDLE && req_valid) begin
            tag_q <= req_addr[ADDR_W-1 -: TAG_W];
            idx_q <= req_addr[ADDR_W-TAG_W-1 -: IDX_W];
            we_q  <= req_we;
         end
         if (state == COMPARE) begin
            hit_q <= set_hit;
         end
      end
   end

   // Next-state decode and Moore-style strobes for the set and memory ports.
   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_hit   = 1'b0;
      set_en     = 1'b1;
      set_check  = 1'b0;
      set_alloc  = 1'b0;
      set_evict  = 1'b0;
      set_change = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      case (state)
         IDLE: begin
            set_en    = 1'b0;
            req_ready = 1'b1;
            if (req_valid) state_nx = COMPARE;
         end
         COMPARE: begin
            set_check = 1'b1;
            if (set_hit) begin
               set_change = we_q;
               state_nx   = RESPOND;
            end else if (set_valid && set_dirty) begin
               state_nx = WRITEBACK;
            end else begin
               state_nx = FILL;
            end
         end
         WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            set_evict = !wb_busy;
            if (mem_ack) state_nx = FILL;
         end
         FILL: begin
            mem_req = 1'b1;
            if (mem_ack) state_nx = ALLOC;
         end
         ALLOC: begin
            set_alloc  = 1'b1;
            set_change = we_q;
            state_nx   = RESPOND;
         end
         RESPOND: begin
            resp_valid = 1'b1;
            resp_hit   = hit_q;
            state_nx   = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign set_idx = idx_q;
   assign set_tag = tag_q;
   // The victim tag is not visible here, so writeback reuses the request tag.
   generate
      if (OFF_W > 0) begin : g_maddr
         assign mem_addr = {tag_q, idx_q, {OFF_W{1'b0}}};
      end else begin : g_maddr_nooff
         assign mem_addr = {tag_q, idx_q};
      end
   endgenerate

`ifdef CACHE_STATS_EN
   // Saturating event counters: hit/miss on response, writeback on its ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hits   <= '0;
         stat_misses <= '0;
         stat_wbacks <= '0;
      end else begin
         if (state == RESPOND && hit_q && stat_hits != '1)
            stat_hits <= stat_hits + STAT_W'(1);
         if (state == RESPOND && !hit_q && stat_misses != '1)
            stat_misses <= stat_misses + STAT_W'(1);
         if (state == WRITEBACK && mem_ack && stat_wbacks != '1)
            stat_wbacks <= stat_wbacks + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Directed testbench for cache_set_ctrl. The set array and memory are modelled
// by directed responses driven per access.
module tb_cache_set_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr;
   logic        resp_valid, resp_hit;
   logic [7:0]  set_idx;
   logic [18:0] set_tag;
   logic        set_en, set_check, set_alloc, set_evict, set_change;
   logic        set_hit, set_dirty, set_valid;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr;

   int n_checks = 0;
   int n_errors = 0;

   // Per-access observations collected by run_access.
   int          lat, wbc, fc, allocs, evicts, rdy_hi, en_lo;
   logic        chg_cmp, chg_alloc, rhit, order_ok, stable;
   logic [31:0] fa, wb_a;

`ifdef CACHE_STATS_EN
   logic [15:0] stat_hits, stat_misses, stat_wbacks;
   logic [1:0]  sat_hits, sat_misses, sat_wbacks;
   logic        s_ready, s_rv, s_rh, s_en, s_chk, s_al, s_ev, s_ch, s_mr, s_mw;
   logic [7:0]  s_idx;
   logic [18:0] s_tag;
   logic [31:0] s_ma;
`endif

   always #5 clk = ~clk;

   cache_set_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_hit(resp_hit),
      .set_idx(set_idx), .set_tag(set_tag), .set_en(set_en), .set_check(set_check),
      .set_alloc(set_alloc), .set_evict(set_evict), .set_change(set_change),
      .set_hit(set_hit), .set_dirty(set_dirty), .set_valid(set_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbacks(stat_wbacks)
`endif
   );

`ifdef CACHE_STATS_EN
   cache_set_ctrl #(.STAT_W(2)) u_sat (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(s_ready), .req_we(req_we), .req_addr(req_addr),
      .resp_valid(s_rv), .resp_hit(s_rh),
      .set_idx(s_idx), .set_tag(s_tag), .set_en(s_en), .set_check(s_chk),
      .set_alloc(s_al), .set_evict(s_ev), .set_change(s_ch),
      .set_hit(set_hit), .set_dirty(set_dirty), .set_valid(set_valid),
      .mem_req(s_mr), .mem_we(s_mw), .mem_addr(s_ma), .mem_ack(mem_ack),
      .stat_hits(sat_hits), .stat_misses(sat_misses), .stat_wbacks(sat_wbacks)
   );
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one request, answer memory after the given number of mem_req
   // cycles (ack in that cycle), and record what the controller did.
   task automatic run_access(input logic we, input logic [31:0] addr,
                             input logic hit, input logic valid, input logic dirty,
                             input int wb_d, input int fill_d, input logic hold_req);
      logic done;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      set_hit   = hit;
      set_valid = valid;
      set_dirty = dirty;
      chk("acc_ready", 32'(req_ready), 32'd1);
      tick;
      if (!hold_req) req_valid = 1'b0;
      lat = -1; wbc = 0; fc = 0; allocs = 0; evicts = 0; rdy_hi = 0; en_lo = 0;
      chg_cmp = 1'b0; chg_alloc = 1'b0; rhit = 1'b0; order_ok = 1'b1; stable = 1'b1;
      fa = '0; wb_a = '0;
      done = 1'b0;
      for (int c = 1; c <= 60 && !done; c++) begin
         if (set_alloc) begin allocs++; chg_alloc = set_change; end
         if (set_evict) evicts++;
         if (set_check) chg_cmp = set_change;
         if (req_ready) rdy_hi++;
         if (!set_en) en_lo++;
         if (mem_req && mem_we) begin
            wbc++;
            if (fc != 0) order_ok = 1'b0;
            wb_a    = mem_addr;
            mem_ack = (wbc == wb_d);
         end else if (mem_req) begin
            fc++;
            if (fc == 1) fa = mem_addr;
            else if (mem_addr !== fa) stable = 1'b0;
            mem_ack = (fc == fill_d);
         end else begin
            mem_ack = 1'b0;
         end
         if (resp_valid) begin
            lat       = c;
            rhit      = resp_hit;
            done      = 1'b1;
            req_valid = 1'b0;
         end
         tick;
      end
      mem_ack   = 1'b0;
      req_valid = 1'b0;
      chk("acc_done", 32'(done), 32'd1);
      chk("resp_drop", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      int resp_seen;
      int waited;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      set_hit = 1'b0; set_dirty = 1'b0; set_valid = 1'b0; mem_ack = 1'b0;
      tick; tick;
      rst = 1'b0;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_memreq", 32'(mem_req), 32'd0);
      chk("rst_resp", 32'(resp_valid), 32'd0);
      chk("rst_en", 32'(set_en), 32'd0);
      chk("rst_maddr", mem_addr, 32'h0);

      // Reset while a fill is outstanding.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hABCD_E0E0;
      tick;
      req_valid = 1'b0;
      waited = 0;
      while (!mem_req && waited < 10) begin tick; waited++; end
      chk("mf_memreq", 32'(mem_req), 32'd1);
      chk("mf_maddr", mem_addr, 32'hABCD_E0E0);
      tick; tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("mf_ready", 32'(req_ready), 32'd1);
      chk("mf_memreq_drop", 32'(mem_req), 32'd0);
      chk("mf_idx", 32'(set_idx), 32'd0);
      resp_seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (resp_valid || mem_req) resp_seen++;
         tick;
      end
      chk("mf_quiet", 32'(resp_seen), 32'd0);

      // Cold read: clean miss, fill acked on its 2nd cycle.
      run_access(1'b0, 32'h1234_5600, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0);
      chk("cold_lat", 32'(lat), 32'd5);
      chk("cold_fills", 32'(fc), 32'd2);
      chk("cold_faddr", fa, 32'h1234_5600);
      chk("cold_wb", 32'(wbc), 32'd0);
      chk("cold_alloc", 32'(allocs), 32'd1);
      chk("cold_hit", 32'(rhit), 32'd0);
      chk("cold_en", 32'(en_lo), 32'd0);

      // Repeat read: hit, no memory traffic.
      run_access(1'b0, 32'h1234_5600, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      chk("hit_lat", 32'(lat), 32'd2);
      chk("hit_mem", 32'(fc + wbc), 32'd0);
      chk("hit_hit", 32'(rhit), 32'd1);
      chk("hit_alloc", 32'(allocs), 32'd0);
      chk("hit_chg", 32'(chg_cmp), 32'd0);

      // Write hit marks the line dirty during the lookup.
      run_access(1'b1, 32'h1234_5604, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      chk("whit_chg", 32'(chg_cmp), 32'd1);
      chk("whit_lat", 32'(lat), 32'd2);
      chk("whit_hit", 32'(rhit), 32'd1);

      // Write miss to the same set with a dirty victim: writeback then fill.
      run_access(1'b1, 32'h8765_5600, 1'b0, 1'b1, 1'b1, 3, 2, 1'b0);
      chk("dm_wb", 32'(wbc), 32'd3);
      chk("dm_fill", 32'(fc), 32'd2);
      chk("dm_order", 32'(order_ok), 32'd1);
      chk("dm_evict", 32'(evicts), 32'd1);
      chk("dm_wbaddr", wb_a, 32'h8765_5600);
      chk("dm_faddr", fa, 32'h8765_5600);
      chk("dm_alloc", 32'(allocs), 32'd1);
      chk("dm_allocchg", 32'(chg_alloc), 32'd1);
      chk("dm_lat", 32'(lat), 32'd8);
      chk("dm_hit", 32'(rhit), 32'd0);

      // Read hit on the newly allocated line.
      run_access(1'b0, 32'h8765_5600, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
      chk("h2_lat", 32'(lat), 32'd2);
`ifdef CACHE_STATS_EN
      chk("st_hits", 32'(stat_hits), 32'd3);
      chk("st_misses", 32'(stat_misses), 32'd2);
      chk("st_wbacks", 32'(stat_wbacks), 32'd1);
`endif

      // Clean-victim miss with a slow fill while the requester keeps req_valid up.
      run_access(1'b0, 32'h0000_0ABC, 1'b0, 1'b1, 1'b0, 0, 7, 1'b1);
      chk("slow_fill", 32'(fc), 32'd7);
      chk("slow_stable", 32'(stable), 32'd1);
      chk("slow_faddr", fa, 32'h0000_0AA0);
      chk("slow_ready", 32'(rdy_hi), 32'd0);
      chk("slow_lat", 32'(lat), 32'd10);
      chk("slow_wb", 32'(wbc), 32'd0);
      chk("slow_alloc_chg", 32'(chg_alloc), 32'd0);

      // A stray ack while idle must be ignored.
      mem_ack = 1'b1;
      tick;
      mem_ack = 1'b0;
      chk("stray_ready", 32'(req_ready), 32'd1);
      chk("stray_memreq", 32'(mem_req), 32'd0);

      run_access(1'b0, 32'h0000_0AA0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      run_access(1'b1, 32'h0000_0AA4, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      chk("h4_hit", 32'(rhit), 32'd1);
`ifdef CACHE_STATS_EN
      chk("st_hits5", 32'(stat_hits), 32'd5);
      chk("st_misses3", 32'(stat_misses), 32'd3);
      chk("sat_hits", 32'(sat_hits), 32'd3);
      chk("sat_misses", 32'(sat_misses), 32'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cache_set_ctrl.md
Name: cache_set_ctrl

Overview:
- FSM sequencing one access at a time through the 4-way cache set array: lookup, victim writeback, line allocation, response.
- Sits between the CPU-side request port and the set array plus the memory-side port.
- Drives the set's en/en_check/en_alloc/en_evict/en_change/tag strobes and consumes hit/dirty/valid back.

Parameters:
- ADDR_W, 32, request address width
- TAG_W, 19, tag field width = addr[ADDR_W-1 -: TAG_W]
- IDX_W, 8, set index width = addr[ADDR_W-TAG_W-1 -: IDX_W]
- STAT_W, 16, width of optional statistics counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  controller can accept request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- resp_valid  out  1  one-cycle pulse: access complete
- resp_hit  out  1  qualifies resp_valid: access was a hit
- set_idx  out  IDX_W  selected set, held for the whole access
- set_tag  out  TAG_W  tag to the set, held for the whole access
- set_en  out  1  set enable (high in every non-IDLE state)
- set_check  out  1  en_check to set
- set_alloc  out  1  en_alloc to set, one-cycle pulse
- set_evict  out  1  en_evict to set, one-cycle pulse
- set_change  out  1  en_change to set (marks dirty on write)
- set_hit  in  1  hit_out from set
- set_dirty  in  1  drty from set
- set_valid  in  1  val from set
- mem_req  out  1  memory transaction request, held until mem_ack
- mem_we  out  1  1 = writeback, 0 = line fill
- mem_addr  out  ADDR_W  line address {tag, idx, zero offset}
- mem_ack  in  1  memory completion, one-cycle pulse

Behaviour:
- Reset (sync, rst high at clk edge): state=IDLE; req_ready=1; every other output 0; latched tag/idx/we=0. Overrides any in-flight access: mem_req drops the same edge, no resp_valid.
- States: IDLE, COMPARE, WRITEBACK, FILL, ALLOC, RESPOND.
- IDLE: req_ready=1. On req_valid: latch tag, idx, we -> COMPARE. set_idx/set_tag are from the latch, never combinational from req_addr.
- COMPARE: set_check=1, sample set_hit.
  - Hit: set_change=req_we -> RESPOND with resp_hit=1.
  - Miss and set_valid & set_dirty -> WRITEBACK.
  - Otherwise -> FILL.
- WRITEBACK: mem_req=1, mem_we=1, set_evict=1 on first cycle only. mem_addr uses the latched idx; the victim tag is not visible, so the latched tag is used. On mem_ack -> FILL.
- FILL: mem_req=1, mem_we=0, mem_addr={tag,idx,0}; wait mem_ack -> ALLOC.
- ALLOC: one cycle. set_alloc=1 (set advances PLRU and writes tag). set_change=req_we (write-allocate marks dirty) -> RESPOND with resp_hit=0.
- RESPOND: resp_valid=1 for exactly one cycle -> IDLE.
- Latency from the req accept edge to resp_valid:
  - hit: 2 cycles;
  - clean miss: 3 cycles + memory wait;
  - dirty miss: two memory waits + 3 cycles.
- mem_ack outside WRITEBACK/FILL is ignored. mem_ack arriving the same cycle mem_req first rises is legal and advances.
- req_valid is ignored while not IDLE; the requester holds it until the accept cycle.
- Only one memory transaction is outstanding at a time.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined:
  - Adds outputs stat_hits, stat_misses, stat_wbacks (STAT_W each).
  - Each increments on the RESPOND(hit), RESPOND(miss) and WRITEBACK-exit edges respectively.
  - Each saturates at all-ones (no wrap).
  - All cleared by rst.
- When undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset mid-FILL (mem_req=1), then rst high one cycle -> next cycle state IDLE, req_ready=1, mem_req=0, no resp_valid.
- Cold read of addr 0x1234_5600 -> one FILL with mem_addr=0x1234_5600 and mem_we=0. set_alloc pulses once. resp_valid with resp_hit=0.
- Repeat the read of 0x1234_5600 -> resp_valid exactly 2 cycles after accept, resp_hit=1, no mem_req.
- Write hit -> set_change=1 in COMPARE. A later miss to the same set with set_dirty=1 -> WRITEBACK (mem_we=1) then FILL, in that order.
- mem_ack delayed 7 cycles in FILL -> mem_req and mem_addr stable throughout. req_valid asserted meanwhile is not accepted (req_ready=0).
- With CACHE_STATS_EN: 3 hits, 2 misses, 1 writeback -> stat_hits=3, stat_misses=2, stat_wbacks=1. With STAT_W=2 and 5 hits -> stat_hits stays 3.
